tc_delay_line_arbiter: RTL
==========================

// Module: tc_delay_line_arbiter
// PURPOSE
//  Shares one programmable-latency delay pipeline between N requesters.
//  - Round-robin arbiter grants one requester per cycle.
//  - Granted payload is delayed by cur_delay cycles, then returned with its requester tag.
//  - Config path changes latency safely: blocks new grants and drains in-flight items first.
//  - Sits between TC datapath clients and the shared delay resource.
// PARAMETERS
//  N_REQ          4   number of requesters (>=2)
//  BIT_WIDTH      8   payload width
//  MAX_DELAY      8   deepest supported latency in cycles (>=1)
//  DEFAULT_DELAY  1   latency loaded at reset (1..MAX_DELAY)
// PORTS
//  clk        in   1                    clock, all logic posedge
//  rst        in   1                    synchronous, active-high reset
//  req        in   N_REQ                per-requester request, level
//  req_data   in   N_REQ*BIT_WIDTH      payload, requester i at [i*BIT_WIDTH +: BIT_WIDTH]
//  gnt        out  N_REQ                one-hot grant, combinational, same cycle as req
//  cfg_load   in   1                    pulse: request new latency
//  cfg_delay  in   $clog2(MAX_DELAY+1)  requested latency, sampled when cfg_load=1
//  cfg_busy   out  1                    high while in DRAIN
//  cfg_err    out  1                    1-cycle pulse: cfg_delay out of range
//  cur_delay  out  $clog2(MAX_DELAY+1)  active latency
//  rsp_valid  out  1                    payload emerging this cycle
//  rsp_tag    out  $clog2(N_REQ)        index of the originating requester
//  rsp_data   out  BIT_WIDTH            delayed payload
// BEHAVIOUR
//  Reset:
//  - Forces state=RUN, rr_ptr=0, cur_delay=DEFAULT_DELAY and inflight=0.
//  - Clears every pipeline valid bit.
//  - rsp_valid/rsp_tag/rsp_data/cfg_busy/cfg_err read 0 in the following cycle.
//  - Reset mid-operation discards in-flight items; no response is produced for them.
//  Arbitration:
//  - In RUN, gnt selects the first asserted req at or after rr_ptr, cyclically.
//  - On a grant to index k, rr_ptr <= (k+1) mod N_REQ. With no grant, rr_ptr holds.
//  - gnt=0 in DRAIN and while rst=1.
//  - A requester holds req/req_data until it sees gnt; gnt means accepted.
//  Latency:
//  - An item granted in cycle t gives rsp_valid=1 in cycle t+cur_delay, with rsp_tag=k and rsp_data=payload.
//  - Throughput is 1 item/cycle. Ordering is FIFO.
//  - rsp_tag/rsp_data are 0 when rsp_valid=0.
//  - inflight counts granted items not yet returned: +1 on grant, -1 on rsp_valid, unchanged when both occur.
//  Config FSM (RUN, DRAIN):
//  - RUN, cfg_load, cfg_delay in 1..MAX_DELAY:
//    - pending <= cfg_delay; go to DRAIN.
//    - A grant in this same cycle is still allowed and is drained at the old latency.
//  - Any state, cfg_load with cfg_delay==0 or >MAX_DELAY:
//    - Ignored; cfg_err=1 next cycle; state unchanged.
//  - DRAIN, valid cfg_load: pending is overwritten; the last one wins.
//  - DRAIN with inflight==0:
//    - cur_delay <= pending; go to RUN.
//    - DRAIN always lasts at least one cycle.
//  - Equal value (cfg_delay==cur_delay) still goes through DRAIN.
//  - cfg_busy = (state==DRAIN), registered.
//  Width rules:
//  - inflight is $clog2(MAX_DELAY+1) bits and never exceeds MAX_DELAY.
//  - Tags are binary-encoded from the one-hot gnt.
// STRUCTURE
//  Package tc_delay_arb_pkg:
//  - typedef state_t {RUN, DRAIN}.
//  - function onehot_to_idx.
//  - localparams TAG_W and DLY_W.
//  Sub-module tc_delay_tap_pipe:
//  - MAX_DELAY-stage shift register of {valid, tag, data}.
//  - Output tap is stage cur_delay-1. The tap changes only when the pipe is empty, so no glitch.
//  Top level holds the arbiter, rr_ptr, the FSM and the inflight counter.
// TESTING
//  1. Reset, DEFAULT_DELAY=1, req=4'b0001 held one cycle, data 8'hA5:
//     gnt=0001 that cycle; next cycle rsp_valid=1, tag=0, data=A5.
//  2. req=4'b1111 held 8 cycles:
//     grants 0,1,2,3,0,1,2,3; rsp tags return in that order, back-to-back.
//  3. cur_delay=3, grants in cycles 0,1 (data 11,22); cfg_load=1, cfg_delay=5 in cycle 1:
//     - cfg_busy from cycle 2; gnt=0 during DRAIN.
//     - Responses 11@3, 22@4.
//     - cur_delay=5 after drain; next grant returns 5 cycles later.
//  4. cfg_load with cfg_delay=0, then with cfg_delay=MAX_DELAY+1:
//     cfg_err pulses each time; cur_delay and state unchanged; grants continue.
//  5. cur_delay=4, 3 items in flight, rst=1 for one cycle:
//     no rsp_valid afterward; cur_delay=DEFAULT_DELAY, rr_ptr=0.
//  6. DRAIN, two cfg_loads (6 then 2) before empty:
//     cur_delay becomes 2.

Source files
------------

// File: rtl/tc_delay_arb_pkg.sv
// Shared types and helpers for the round-robin delay-line arbiter.
// Widths below match the default configuration and are used as sub-module defaults.
package tc_delay_arb_pkg;

  localparam int N_REQ_DEF     = 4;
  localparam int MAX_DELAY_DEF = 8;
  localparam int TAG_W         = $clog2(N_REQ_DEF);
  localparam int DLY_W         = $clog2(MAX_DELAY_DEF + 1);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // OR-reduction of set-bit indices: exact for a one-hot input, 0 when empty.
  function automatic int onehot_to_idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/tc_delay_tap_pipe.sv
// MAX_DELAY-stage shift register of {valid, tag, data}; the output is tapped at stage dly-1.
// Valid bits past the tap are dropped so a later, longer tap never replays a returned item.
module tc_delay_tap_pipe
  import tc_delay_arb_pkg::*;
#(
  parameter int MAX_DELAY = MAX_DELAY_DEF,
  parameter int BIT_WIDTH = 8,
  parameter int TAG_BITS  = TAG_W,
  parameter int DLY_BITS  = DLY_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [TAG_BITS-1:0]  in_tag,
  input  logic [BIT_WIDTH-1:0] in_data,
  input  logic [DLY_BITS-1:0]  dly,
  output logic                 out_valid,
  output logic [TAG_BITS-1:0]  out_tag,
  output logic [BIT_WIDTH-1:0] out_data
);

  logic [MAX_DELAY-1:0] vld;
  logic [TAG_BITS-1:0]  tag_q [MAX_DELAY];
  logic [BIT_WIDTH-1:0] dat_q [MAX_DELAY];

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < MAX_DELAY; i++) begin
        vld[i] <= vld[i-1] && (i < int'(dly));
      end
    end
  end

  // NOTE: payload storage is deliberately not reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    tag_q[0] <= in_tag;
    dat_q[0] <= in_data;
    for (int i = 1; i < MAX_DELAY; i++) begin
      tag_q[i] <= tag_q[i-1];
      dat_q[i] <= dat_q[i-1];
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_tag   = '0;
    out_data  = '0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (i == int'(dly) - 1 && vld[i]) begin
        out_valid = 1'b1;
        out_tag   = tag_q[i];
        out_data  = dat_q[i];
      end
    end
  end

endmodule

// File: rtl/tc_delay_line_arbiter.sv
// Round-robin arbiter feeding one shared programmable-latency pipe; latency changes
// are applied only after the pipe drains, with new grants blocked meanwhile.
module tc_delay_line_arbiter
  import tc_delay_arb_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int BIT_WIDTH     = 8,
  parameter int MAX_DELAY     = 8,
  parameter int DEFAULT_DELAY = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req,
  input  logic [N_REQ*BIT_WIDTH-1:0]       req_data,
  output logic [N_REQ-1:0]                 gnt,
  input  logic                             cfg_load,
  input  logic [$clog2(MAX_DELAY+1)-1:0]   cfg_delay,
  output logic                             cfg_busy,
  output logic                             cfg_err,
  output logic [$clog2(MAX_DELAY+1)-1:0]   cur_delay,
  output logic                             rsp_valid,
  output logic [$clog2(N_REQ)-1:0]         rsp_tag,
  output logic [BIT_WIDTH-1:0]             rsp_data
);

  localparam int TAG_BITS = $clog2(N_REQ);
  localparam int DLY_BITS = $clog2(MAX_DELAY + 1);

  state_t                state, state_nxt;
  logic [TAG_BITS-1:0]   rr_ptr, rr_nxt, gnt_tag;
  logic [DLY_BITS-1:0]   cur_q, cur_nxt, pending, pending_nxt, inflight, inflight_nxt;
  logic [BIT_WIDTH-1:0]  gnt_data;
  logic                  gnt_any, cfg_bad, cfg_ok, cfg_err_q;
  int                    idx;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_data = '0;
    idx      = 0;
    if (!rst && state == RUN) begin
      for (int o = 0; o < N_REQ; o++) begin
        idx = (int'(rr_ptr) + o) % N_REQ;
        if (!gnt_any && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_any  = 1'b1;
        end
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) gnt_data = req_data[i*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  assign gnt_tag = TAG_BITS'(onehot_to_idx(32'(gnt)));

  always_comb begin
    cfg_bad      = cfg_load && (cfg_delay == '0 || int'(cfg_delay) > MAX_DELAY);
    cfg_ok       = cfg_load && !cfg_bad;
    state_nxt    = state;
    pending_nxt  = pending;
    cur_nxt      = cur_q;
    rr_nxt       = rr_ptr;
    inflight_nxt = inflight;

    if (gnt_any) begin
      rr_nxt = (int'(gnt_tag) == N_REQ - 1) ? '0 : gnt_tag + TAG_BITS'(1);
    end

    if (gnt_any && !rsp_valid)      inflight_nxt = inflight + DLY_BITS'(1);
    else if (!gnt_any && rsp_valid) inflight_nxt = inflight - DLY_BITS'(1);

    case (state)
      RUN: begin
        if (cfg_ok) begin
          pending_nxt = cfg_delay;
          state_nxt   = DRAIN;
        end
      end
      DRAIN: begin
        if (cfg_ok) pending_nxt = cfg_delay;
        // A load arriving in the same cycle the pipe is empty still wins.
        if (inflight == '0) begin
          cur_nxt   = pending_nxt;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      rr_ptr    <= '0;
      cur_q     <= DLY_BITS'(DEFAULT_DELAY);
      pending   <= DLY_BITS'(DEFAULT_DELAY);
      inflight  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      cur_q     <= cur_nxt;
      pending   <= pending_nxt;
      inflight  <= inflight_nxt;
      cfg_err_q <= cfg_bad;
    end
  end

  assign cur_delay = cur_q;
  assign cfg_busy  = (state == DRAIN);
  assign cfg_err   = cfg_err_q;

  tc_delay_tap_pipe #(
    .MAX_DELAY (MAX_DELAY),
    .BIT_WIDTH (BIT_WIDTH),
    .TAG_BITS  (TAG_BITS),
    .DLY_BITS  (DLY_BITS)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (gnt_any),
    .in_tag    (gnt_tag),
    .in_data   (gnt_data),
    .dly       (cur_q),
    .out_valid (rsp_valid),
    .out_tag   (rsp_tag),
    .out_data  (rsp_data)
  );

endmodule
